// File: rtl/ram_bist_march_ctrl_if.sv
// RAM-side BIST bus: strobes, address and write data out to the column, forwarded read data back.
// Latency: none of its own; read data returns RD_LATENCY cycles after re_o.
// Backpressure: none; the RAM column accepts one strobe per cycle unconditionally.
//
// Signals: bist_enable_o, y_select_o[NUM_Y], addr_o[ADDR_W], wrdata_o[DATA_W], we_o, re_o
//          driven by the controller (master); bist_rddata_i[DATA_W] driven by the chain (slave).
interface ram_bist_march_ctrl_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 40,
    parameter int NUM_Y  = 4
);
    logic              bist_enable_o;
    logic [NUM_Y-1:0]  y_select_o;
    logic [ADDR_W-1:0] addr_o;
    logic [DATA_W-1:0] wrdata_o;
    logic              we_o;
    logic              re_o;
    logic [DATA_W-1:0] bist_rddata_i;

    modport master (
        output bist_enable_o, y_select_o, addr_o, wrdata_o, we_o, re_o,
        input  bist_rddata_i
    );

    modport slave (
        input  bist_enable_o, y_select_o, addr_o, wrdata_o, we_o, re_o,
        output bist_rddata_i
    );
endinterface

// File: rtl/ram_bist_march_ctrl.sv
// March BIST sequencer (W0 / R0W1 / R1 per RAM) with pipelined read-data checker.
// Latency: start to done_o is NUM_Y*(4*2^ADDR_W + RD_LATENCY + 1) cycles; compare lags re_o by RD_LATENCY.
// Backpressure: none; one strobe per cycle, start_i ignored while busy.
//
// Ports: clk_i, rst_i (async, active-high), start_i; ram (master modport of ram_bist_march_ctrl_if);
//        busy_o, done_o, fail_o, fail_y_o, fail_addr_o, fail_count_o (saturating at 255).
// Build option: BIST_STOP_ON_FAIL_EN -- stop strobing on the first mismatch, drain, then finish.
module ram_bist_march_ctrl #(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 40,
    parameter int NUM_Y      = 4,
    parameter int Y_W        = 2,
    parameter int RD_LATENCY = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    ram_bist_march_ctrl_if.master ram,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  fail_o,
    output logic [Y_W-1:0]        fail_y_o,
    output logic [ADDR_W-1:0]     fail_addr_o,
    output logic [7:0]            fail_count_o
);
    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam int                DRN_W    = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [DRN_W-1:0]  DRN_LAST = DRN_W'(RD_LATENCY - 1);
    localparam logic [Y_W-1:0]    Y_LAST   = Y_W'(NUM_Y - 1);
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP_EN = 1'b1;
`else
    localparam bit STOP_EN = 1'b0;
`endif

    // Checkerboard background: even bits set.
    function automatic logic [DATA_W-1:0] march_pat();
        logic [DATA_W-1:0] p;
        for (int i = 0; i < DATA_W; i++) p[i] = (i % 2 == 0);
        return p;
    endfunction
    localparam logic [DATA_W-1:0] PAT = march_pat();

    typedef enum logic [2:0] {S_IDLE, S_W0, S_R0W1, S_R1, S_DRAIN, S_NEXT_Y, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [Y_W-1:0]    y_q, y_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic              phase_q, phase_d;   // R0W1: 0 = read cycle, 1 = write cycle
    logic              stop_q, stop_d;     // early stop taken; DRAIN ends in DONE
    logic              we, re, exp_inv, running, start_ok, halt, mismatch;
    logic [DATA_W-1:0] wdat;

    // Compare pipeline: {valid, expected-is-inverted, y, addr} travels alongside the read.
    logic [RD_LATENCY-1:0] pv, pinv;
    logic [Y_W-1:0]        py [RD_LATENCY];
    logic [ADDR_W-1:0]     pa [RD_LATENCY];

    assign mismatch = pv[RD_LATENCY-1] &&
                      (ram.bist_rddata_i != (pinv[RD_LATENCY-1] ? ~PAT : PAT));
    assign halt     = STOP_EN && mismatch;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            y_q     <= '0;
            drain_q <= '0;
            phase_q <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            y_q     <= y_d;
            drain_q <= drain_d;
            phase_q <= phase_d;
            stop_q  <= stop_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        y_d      = y_q;
        drain_d  = drain_q;
        phase_d  = phase_q;
        stop_d   = stop_q;
        we       = 1'b0;
        re       = 1'b0;
        exp_inv  = 1'b0;
        wdat     = '0;
        running  = 1'b0;
        start_ok = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    start_ok = 1'b1;
                    state_d  = S_W0;
                    addr_d   = '0;
                    y_d      = '0;
                    drain_d  = '0;
                    phase_d  = 1'b0;
                    stop_d   = 1'b0;
                end
            end
            S_W0, S_R0W1, S_R1: begin
                running = 1'b1;
                if (halt) begin
                    // Strobes are suppressed from the cycle the mismatch is seen.
                    state_d = S_DRAIN;
                    drain_d = '0;
                    stop_d  = 1'b1;
                end else if (state_q == S_W0) begin
                    we   = 1'b1;
                    wdat = PAT;
                    if (addr_q == ADDR_MAX) begin
                        state_d = S_R0W1;
                        addr_d  = '0;
                        phase_d = 1'b0;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end else if (state_q == S_R0W1) begin
                    phase_d = ~phase_q;
                    if (!phase_q) begin
                        re = 1'b1;
                    end else begin
                        we   = 1'b1;
                        wdat = ~PAT;
                        // R1 starts from the top, which is where addr already sits.
                        if (addr_q == ADDR_MAX) state_d = S_R1;
                        else                    addr_d  = addr_q + 1'b1;
                    end
                end else begin
                    re      = 1'b1;
                    exp_inv = 1'b1;
                    if (addr_q == '0) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end else begin
                        addr_d = addr_q - 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                running = 1'b1;
                if (drain_q == DRN_LAST) begin
                    if (stop_q || halt || (y_q == Y_LAST)) state_d = S_DONE;
                    else                                   state_d = S_NEXT_Y;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            S_NEXT_Y: begin
                running = 1'b1;
                y_d     = y_q + 1'b1;
                addr_d  = '0;
                phase_d = 1'b0;
                state_d = S_W0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ram.bist_enable_o = running;
    assign ram.y_select_o    = running ? (NUM_Y'(1) << y_q) : '0;
    assign ram.addr_o        = addr_q;
    assign ram.wrdata_o      = wdat;
    assign ram.we_o          = we;
    assign ram.re_o          = re;
    assign busy_o            = running;
    assign done_o            = (state_q == S_DONE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pv   <= '0;
            pinv <= '0;
            for (int k = 0; k < RD_LATENCY; k++) begin
                py[k] <= '0;
                pa[k] <= '0;
            end
        end else begin
            pv[0]   <= re;
            pinv[0] <= exp_inv;
            py[0]   <= y_q;
            pa[0]   <= addr_q;
            for (int k = 1; k < RD_LATENCY; k++) begin
                pv[k]   <= pv[k-1];
                pinv[k] <= pinv[k-1];
                py[k]   <= py[k-1];
                pa[k]   <= pa[k-1];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fail_o       <= 1'b0;
            fail_y_o     <= '0;
            fail_addr_o  <= '0;
            fail_count_o <= '0;
        end else if (start_ok) begin
            fail_o       <= 1'b0;
            fail_y_o     <= '0;
            fail_addr_o  <= '0;
            fail_count_o <= '0;
        end else if (mismatch) begin
            fail_o <= 1'b1;
            if (fail_count_o != 8'hFF) fail_count_o <= fail_count_o + 8'd1;
            // Only the first failing location after start is kept.
            if (!fail_o) begin
                fail_y_o    <= py[RD_LATENCY-1];
                fail_addr_o <= pa[RD_LATENCY-1];
            end
        end
    end
endmodule

// File: tb/tb_ram_bist_march_ctrl.sv
// Bench for ram_bist_march_ctrl: small-RAM instance with injectable stuck-at faults, plus a large
// instance behind a RAM that inverts every read to drive the mismatch counter into saturation.
// Expected results come from a direct walk of the march algorithm over an array model.
module tb_ram_bist_march_ctrl;
    localparam int AW  = 3;
    localparam int DW  = 40;
    localparam int NY  = 2;
    localparam int YW  = 1;
    localparam int RL  = 2;
    localparam int N   = 1 << AW;
    localparam int AW2 = 8;
    localparam int N2  = 1 << AW2;
    localparam int FULL_LAT = NY * (4 * N + RL + 1);
`ifdef BIST_STOP_ON_FAIL_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start1 = 1'b0;
    logic start2 = 1'b0;
    always #5 clk = ~clk;

    ram_bist_march_ctrl_if #(.ADDR_W(AW),  .DATA_W(DW), .NUM_Y(NY)) bus1 ();
    ram_bist_march_ctrl_if #(.ADDR_W(AW2), .DATA_W(DW), .NUM_Y(1))  bus2 ();

    logic           busy1, done1, fail1;
    logic [YW-1:0]  fy1;
    logic [AW-1:0]  fa1;
    logic [7:0]     fc1;
    logic           busy2, done2, fail2;
    logic [0:0]     fy2;
    logic [AW2-1:0] fa2;
    logic [7:0]     fc2;

    ram_bist_march_ctrl #(.ADDR_W(AW), .DATA_W(DW), .NUM_Y(NY), .Y_W(YW), .RD_LATENCY(RL)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start1), .ram(bus1),
        .busy_o(busy1), .done_o(done1), .fail_o(fail1),
        .fail_y_o(fy1), .fail_addr_o(fa1), .fail_count_o(fc1)
    );

    ram_bist_march_ctrl #(.ADDR_W(AW2), .DATA_W(DW), .NUM_Y(1), .Y_W(1), .RD_LATENCY(RL)) dut2 (
        .clk_i(clk), .rst_i(rst), .start_i(start2), .ram(bus2),
        .busy_o(busy2), .done_o(done2), .fail_o(fail2),
        .fail_y_o(fy2), .fail_addr_o(fa2), .fail_count_o(fc2)
    );

    // RAM column 1: per-word stuck-at masks applied on read; RAM read stage + forwarding stage.
    logic [DW-1:0] mem1 [NY][N];
    logic [DW-1:0] sa0  [NY][N];
    logic [DW-1:0] sa1  [NY][N];
    logic [DW-1:0] rd1_s1;
    always @(posedge clk) begin
        rd1_s1 <= '0;
        for (int y = 0; y < NY; y++) begin
            if (bus1.y_select_o[y]) begin
                if (bus1.we_o) mem1[y][bus1.addr_o] <= bus1.wrdata_o;
                if (bus1.re_o)
                    rd1_s1 <= (mem1[y][bus1.addr_o] & ~sa0[y][bus1.addr_o]) | sa1[y][bus1.addr_o];
            end
        end
        bus1.bist_rddata_i <= rd1_s1;
    end

    // RAM column 2: every read comes back fully inverted.
    logic [DW-1:0] mem2 [N2];
    logic [DW-1:0] rd2_s1;
    always @(posedge clk) begin
        rd2_s1 <= '0;
        if (bus2.y_select_o[0] && bus2.we_o) mem2[bus2.addr_o] <= bus2.wrdata_o;
        if (bus2.y_select_o[0] && bus2.re_o) rd2_s1 <= ~mem2[bus2.addr_o];
        bus2.bist_rddata_i <= rd2_s1;
    end

    int n_chk  = 0;
    int n_fail = 0;
    logic [DW-1:0] pat;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        chk(tag, {bus1.bist_enable_o, bus1.y_select_o, bus1.we_o, bus1.re_o, busy1, done1,
                  fail1, fy1, fa1, fc1, bus1.addr_o, bus1.wrdata_o}, 64'd0);
    endtask

    task automatic clear_faults();
        for (int y = 0; y < NY; y++)
            for (int a = 0; a < N; a++) begin
                sa0[y][a] = '0;
                sa1[y][a] = '0;
            end
    endtask

    // March algorithm over an array: W0 up, (R P, W ~P) up, R ~P down, per RAM in order.
    task automatic ref_model(output int cnt, output int fy, output int fa);
        logic [DW-1:0] m [N];
        logic [DW-1:0] rd;
        bit first;
        cnt = 0; fy = 0; fa = 0; first = 1'b1;
        for (int y = 0; y < NY; y++) begin
            for (int a = 0; a < N; a++) m[a] = pat;
            for (int pass = 0; pass < 2; pass++) begin
                for (int i = 0; i < N; i++) begin
                    int a;
                    a  = (pass == 0) ? i : N - 1 - i;
                    rd = (m[a] & ~sa0[y][a]) | sa1[y][a];
                    if (rd != ((pass == 0) ? pat : ~pat)) begin
                        if (first) begin fy = y; fa = a; first = 1'b0; end
                        if (cnt < 255) cnt++;
                    end
                    if (pass == 0) m[a] = ~pat;
                end
            end
        end
    endtask

    task automatic run1(input string name, input int spur);
        int ecnt, efy, efa, lat, busy_n, we_n, re_n, viol;
        logic [NY-1:0] last;
        logic [NY-1:0] seq [$];
        bit stopped;
        ref_model(ecnt, efy, efa);
        stopped = STOP && (ecnt > 0);
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        chk($sformatf("%s_clr_on_start", name), {done1, fail1, fc1}, 64'd0);
        lat = 1; busy_n = 0; we_n = 0; re_n = 0; viol = 0; last = '0;
        while (!done1 && lat < 3000) begin
            busy_n += int'(busy1);
            we_n   += int'(bus1.we_o);
            re_n   += int'(bus1.re_o);
            if (bus1.we_o && bus1.re_o) viol++;
            if (bus1.y_select_o != '0 && bus1.y_select_o != last) seq.push_back(bus1.y_select_o);
            last = bus1.y_select_o;
            @(negedge clk);
            lat++;
            start1 = (lat == spur);
        end
        start1 = 1'b0;
        chk($sformatf("%s_done_seen", name), done1, 1);
        chk($sformatf("%s_fail", name), fail1, (ecnt > 0));
        if (ecnt > 0) begin
            chk($sformatf("%s_fail_y", name), fy1, efy);
            chk($sformatf("%s_fail_addr", name), fa1, efa);
        end
        if (!stopped) begin
            chk($sformatf("%s_latency", name), lat, FULL_LAT);
            chk($sformatf("%s_busy_cycles", name), busy_n, FULL_LAT - 1);
            chk($sformatf("%s_we_count", name), we_n, NY * 2 * N);
            chk($sformatf("%s_re_count", name), re_n, NY * 2 * N);
            chk($sformatf("%s_fail_count", name), fc1, ecnt);
            chk($sformatf("%s_ysel_len", name), seq.size(), NY);
            for (int i = 0; i < NY && i < seq.size(); i++)
                chk($sformatf("%s_ysel_%0d", name, i), seq[i], 64'd1 << i);
        end else begin
            chk($sformatf("%s_stop_early", name), lat < FULL_LAT, 1);
            chk($sformatf("%s_count_min", name), fc1 >= 8'd1, 1);
        end
        chk($sformatf("%s_we_re_excl", name), viol, 0);
        chk($sformatf("%s_idle_bus", name), {bus1.y_select_o, bus1.bist_enable_o, busy1}, 64'd0);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < DW; i++) pat[i] = (i % 2 == 0);
        clear_faults();
        repeat (3) @(negedge clk);
        check_quiet("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_quiet("idle_after_reset");

        run1("clean", 0);

        clear_faults();
        sa1[1][5][0] = 1'b1;
        run1("y1_a5_b0_sa1", 0);

        clear_faults();
        for (int y = 0; y < NY; y++)
            for (int a = 0; a < N; a++) sa0[y][a][39] = 1'b1;
        run1("b39_sa0_all", 0);

        clear_faults();
        run1("restart_clears", 0);

        run1("spurious_start", 10);

        for (int t = 0; t < 6; t++) begin
            clear_faults();
            for (int f = $urandom_range(0, 3); f > 0; f--) begin
                int y, a, b;
                y = $urandom_range(0, NY - 1);
                a = $urandom_range(0, N - 1);
                b = $urandom_range(0, DW - 1);
                if ($urandom_range(0, 1) == 1) sa1[y][a][b] = 1'b1;
                else                           sa0[y][a][b] = 1'b1;
            end
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run1($sformatf("rand%0d", t), $urandom_range(0, 1) == 1 ? $urandom_range(2, 60) : 0);
        end

        // Asynchronous reset partway into R0W1 (W0 takes N cycles).
        clear_faults();
        sa0[0][2][4] = 1'b1;
        @(negedge clk); start1 = 1'b1;
        @(negedge clk); start1 = 1'b0;
        repeat (N + 5) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_quiet("async_reset_mid_r0w1");
        @(negedge clk);
        rst = 1'b0;
        clear_faults();
        run1("after_reset", 0);

        // Saturation: every one of the 2*N2 reads mismatches.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 3000) begin
            @(negedge clk);
            lat++;
        end
        chk("sat_done_seen", done2, 1);
        chk("sat_latency", lat, 4 * N2 + RL + 1);
        chk("sat_fail", fail2, 1);
        chk("sat_first_y", fy2, 0);
        chk("sat_first_addr", fa2, 0);
        chk("sat_count", fc2, (2 * N2 > 255) ? 255 : 2 * N2);
        repeat (5) @(negedge clk);
        chk("sat_count_hold", fc2, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
